// File: rtl/fetch_queue_if.sv
// Fetch-to-issue bus: a fetched instruction pair in, the two oldest queued instructions out.
interface fetch_queue_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int PC_W   = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_instr1;
  logic [DATA_W-1:0] in_instr2;
  logic [PC_W-1:0]   in_pc;
  logic              in_ready;
  logic [1:0]        out_take;
  logic              out_valid1;
  logic              out_valid2;
  logic [DATA_W-1:0] out_instr1;
  logic [DATA_W-1:0] out_instr2;
  logic [PC_W-1:0]   out_pc1;
  logic [PC_W-1:0]   out_pc2;
  logic [CW-1:0]     count;

  modport master (
    output flush, in_valid, in_instr1, in_instr2, in_pc, out_take,
    input  in_ready, out_valid1, out_valid2, out_instr1, out_instr2, out_pc1, out_pc2, count
  );

  modport slave (
    input  flush, in_valid, in_instr1, in_instr2, in_pc, out_take,
    output in_ready, out_valid1, out_valid2, out_instr1, out_instr2, out_pc1, out_pc2, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Dual-push/dual-pop instruction fetch FIFO; pair visible one cycle after push (FWFT outputs).
// Backpressure: in_ready drops when fewer than two entries are free on the registered count.
module fetch_queue #(
  parameter int                DEPTH   = 8,
  parameter int                DATA_W  = 32,
  parameter int                PC_W    = 8,
  parameter int                PC_STEP = 4,
  parameter logic [DATA_W-1:0] NOP     = 'h13
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [PC_W-1:0]   pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic [AW-1:0] wr_ptr_p1;
  logic [AW-1:0] rd_ptr_p1;
  logic [1:0]    take_sat;
  logic [CW-1:0] eff_take;
  logic [CW-1:0] cnt_nxt;
  logic          push_vld;
  entry_t        head0;
  entry_t        head1;

  assign wr_ptr_p1 = wr_ptr + AW'(1);
  assign rd_ptr_p1 = rd_ptr + AW'(1);

  // Ready looks only at registered occupancy, so a same-cycle pop never admits a pair.
  assign bus.in_ready = (CW'(DEPTH) - cnt) >= CW'(2);
  assign push_vld     = bus.in_valid & bus.in_ready & ~bus.flush;

  // Over-take is clipped to what is actually held.
  assign take_sat = (bus.out_take == 2'd3) ? 2'd2 : bus.out_take;
  assign eff_take = (CW'(take_sat) > cnt) ? cnt : CW'(take_sat);
  assign cnt_nxt  = cnt + (push_vld ? CW'(2) : CW'(0)) - eff_take;

  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem[wr_ptr]    <= '{instr: bus.in_instr1, pc: bus.in_pc};
      mem[wr_ptr_p1] <= '{instr: bus.in_instr2, pc: bus.in_pc + PC_W'(PC_STEP)};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(2);
      rd_ptr <= rd_ptr + AW'(eff_take);
      cnt    <= cnt_nxt;
    end
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr_p1];

  assign bus.count      = cnt;
  assign bus.out_valid1 = cnt >= CW'(1);
  assign bus.out_valid2 = cnt >= CW'(2);
  assign bus.out_instr1 = bus.out_valid1 ? head0.instr : NOP;
  assign bus.out_instr2 = bus.out_valid2 ? head1.instr : NOP;
  assign bus.out_pc1    = bus.out_valid1 ? head0.pc : '0;
  assign bus.out_pc2    = bus.out_valid2 ? head1.pc : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: driver queues expected entries, monitor checks outputs and retires them.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h13;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  ent_t        sb_q[$];
  bit          pend_vld = 1'b0;
  logic [31:0] pend_i1, pend_i2;
  logic [7:0]  pend_pc;

  fetch_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(8)) bus();

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(8), .PC_STEP(4), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus at the falling edge; the pair accepted on the previous
  // edge is committed to the scoreboard first, so sb_q always mirrors post-edge contents.
  task automatic drive(input bit v, input logic [31:0] i1, input logic [31:0] i2,
                       input logic [7:0] pc, input logic [1:0] take, input bit fl);
    ent_t e;
    @(negedge clk);
    if (pend_vld) begin
      e.instr = pend_i1; e.pc = pend_pc;         sb_q.push_back(e);
      e.instr = pend_i2; e.pc = pend_pc + 8'd4;  sb_q.push_back(e);
    end
    bus.in_valid  = v;
    bus.in_instr1 = i1;
    bus.in_instr2 = i2;
    bus.in_pc     = pc;
    bus.out_take  = take;
    bus.flush     = fl;
    pend_vld = v && !fl && ((DEPTH - sb_q.size()) >= 2);
    pend_i1  = i1;
    pend_i2  = i2;
    pend_pc  = pc;
  endtask

  task automatic idle(input logic [1:0] take);
    drive(1'b0, 32'h0, 32'h0, 8'h0, take, 1'b0);
  endtask

  task automatic push(input logic [31:0] i1, input logic [31:0] i2, input logic [7:0] pc);
    drive(1'b1, i1, i2, pc, 2'd0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"},  bus.count, 0);
    chk({tag, "_ready"},  bus.in_ready, 1);
    chk({tag, "_v1"},     bus.out_valid1, 0);
    chk({tag, "_v2"},     bus.out_valid2, 0);
    chk({tag, "_i1"},     bus.out_instr1, NOP);
    chk({tag, "_i2"},     bus.out_instr2, NOP);
    chk({tag, "_pc1"},    bus.out_pc1, 0);
    chk({tag, "_pc2"},    bus.out_pc2, 0);
  endtask

  // Monitor: between edges, compare visible state with the model, then retire what issue takes.
  initial begin : monitor
    int n;
    int k;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        n = sb_q.size();
        chk("count", bus.count, n);
        chk("in_ready", bus.in_ready, (DEPTH - n) >= 2);
        chk("valid1", bus.out_valid1, n >= 1);
        chk("valid2", bus.out_valid2, n >= 2);
        if (n >= 1) begin
          chk("instr1", bus.out_instr1, sb_q[0].instr);
          chk("pc1", bus.out_pc1, sb_q[0].pc);
        end else begin
          chk("instr1_nop", bus.out_instr1, NOP);
          chk("pc1_zero", bus.out_pc1, 0);
        end
        if (n >= 2) begin
          chk("instr2", bus.out_instr2, sb_q[1].instr);
          chk("pc2", bus.out_pc2, sb_q[1].pc);
        end else begin
          chk("instr2_nop", bus.out_instr2, NOP);
          chk("pc2_zero", bus.out_pc2, 0);
        end
        if (bus.flush) begin
          sb_q.delete();
        end else begin
          k = (bus.out_take == 2'd3) ? 2 : int'(bus.out_take);
          if (k > n) k = n;
          repeat (k) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr1 = '0; bus.in_instr2 = '0;
    bus.in_pc = '0; bus.out_take = '0;
    #3;
    chk_reset_vals("rst");
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Single pair, one-cycle visibility.
    push(32'h00500093, 32'h00A00113, 8'h10);
    idle(2'd0);
    #3;
    chk("t1_v1", bus.out_valid1, 1);
    chk("t1_v2", bus.out_valid2, 1);
    chk("t1_pc1", bus.out_pc1, 8'h10);
    chk("t1_pc2", bus.out_pc2, 8'h14);
    chk("t1_count", bus.count, 2);

    // Fill to DEPTH; the next pair is refused, and a pop does not admit a pair that cycle.
    push(32'h1111_0001, 32'h1111_0002, 8'h18);
    push(32'h1111_0003, 32'h1111_0004, 8'h20);
    push(32'h1111_0005, 32'h1111_0006, 8'h28);
    push(32'hDEAD_0001, 32'hDEAD_0002, 8'h30);
    #3;
    chk("t2_full_count", bus.count, 8);
    chk("t2_full_ready", bus.in_ready, 0);
    drive(1'b1, 32'hDEAD_0003, 32'hDEAD_0004, 8'h38, 2'd2, 1'b0);
    #3;
    chk("t2_ignored_count", bus.count, 8);
    idle(2'd0);
    #3;
    chk("t3_count", bus.count, 6);
    chk("t3_ready", bus.in_ready, 1);

    // Drain down to one entry, then over-take.
    idle(2'd2);
    idle(2'd2);
    idle(2'd1);
    idle(2'd2);
    #3;
    chk("t4_count1", bus.count, 1);
    idle(2'd0);
    #3;
    chk("t4_count0", bus.count, 0);
    chk("t4_v1", bus.out_valid1, 0);
    chk("t4_i1", bus.out_instr1, NOP);

    // Build contents that straddle the end of the storage and drain one at a time.
    push(32'hA000_0000, 32'hA000_0001, 8'h40);
    push(32'hA000_0002, 32'hA000_0003, 8'h48);
    push(32'hA000_0004, 32'hA000_0005, 8'h50);
    idle(2'd2);
    idle(2'd2);
    push(32'hA000_0006, 32'hA000_0007, 8'h58);
    push(32'hA000_0008, 32'hA000_0009, 8'h60);
    push(32'hA000_000A, 32'hA000_000B, 8'h68);
    repeat (8) idle(2'd1);
    idle(2'd0);
    #3;
    chk("t5_empty", bus.count, 0);

    // Flush with a concurrent push and take.
    push(32'hB000_0000, 32'hB000_0001, 8'h70);
    push(32'hB000_0002, 32'hB000_0003, 8'h78);
    push(32'hB000_0004, 32'hB000_0005, 8'h80);
    idle(2'd1);
    drive(1'b1, 32'hB000_0006, 32'hB000_0007, 8'h88, 2'd2, 1'b1);
    #3;
    chk("t6_pre_count", bus.count, 5);
    idle(2'd0);
    #3;
    chk("t6_count", bus.count, 0);
    chk("t6_ready", bus.in_ready, 1);
    chk("t6_v1", bus.out_valid1, 0);
    chk("t6_v2", bus.out_valid2, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom, 8'($urandom), 2'($urandom),
            $urandom_range(0, 59) == 0);
    end

    // Asynchronous reset mid-stream, observed before the next rising edge.
    push(32'hC000_0000, 32'hC000_0001, 8'hF8);
    idle(2'd0);
    #3;
    chk("pre_rst_v1", bus.out_valid1, 1);
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk_reset_vals("mid_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
